node_work_queue: RTL and testbench

NODE_WORK_QUEUE -- requirements
Module: node_work_queue

---
 rtl/node_work_queue.sv | 114 +++++++++++
 tb/tb_node_work_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/node_work_queue.sv
// Coalescing work queue: circular FIFO of {node_idx, accum_val} entries.
// A push whose node is already queued adds into that entry instead of appending.
module node_work_queue #(
    parameter int PARAM_NODE_IDX_WIDTH  = 9,
    parameter int PARAM_ACCUM_VAL_WIDTH = 24,
    parameter int PARAM_FIFO_DEPTH      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  push_valid,
    output logic                                  push_ready,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]       push_node_idx,
    input  logic [PARAM_ACCUM_VAL_WIDTH-1:0]      push_accum_val,
    output logic                                  pop_valid,
    input  logic                                  pop_ready,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]       pop_node_idx,
    output logic [PARAM_ACCUM_VAL_WIDTH-1:0]      pop_accum_val,
    output logic [$clog2(PARAM_FIFO_DEPTH):0]     count,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  sat_flag
);

    localparam int NW    = PARAM_NODE_IDX_WIDTH;
    localparam int AW    = PARAM_ACCUM_VAL_WIDTH;
    localparam int DEPTH = PARAM_FIFO_DEPTH;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    logic [NW-1:0] node_q  [DEPTH];
    logic [AW-1:0] accum_q [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          sat_q;

    logic          hit_any;
    logic          head_match;
    logic          hit_eff;
    logic [PW-1:0] hit_idx;
    logic [PW-1:0] off;
    logic          push_fire;
    logic          pop_fire;
    logic          miss_fire;
    logic          hit_fire;
    logic [AW:0]   sum;
    logic [AW-1:0] sat_sum;

    // Occupancy of a slot is its distance from the head compared to count,
    // so match logic never depends on stale storage.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count_q) && (node_q[i] == push_node_idx)) begin
                hit_any = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign head_match = hit_any && (hit_idx == rd_ptr);
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full || hit_any;
    assign pop_valid  = !empty;
    assign pop_node_idx  = node_q[rd_ptr];
    assign pop_accum_val = accum_q[rd_ptr];
    assign count      = count_q;
    assign sat_flag   = sat_q;

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;
    // A head being popped cannot absorb the add; the push re-enqueues instead.
    assign hit_eff   = hit_any && !(pop_fire && head_match);
    assign miss_fire = push_fire && !hit_eff;
    assign hit_fire  = push_fire && hit_eff;

    assign sum     = {1'b0, accum_q[hit_idx]} + {1'b0, push_accum_val};
    assign sat_sum = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (clr) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            if (miss_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(miss_fire) - CW'(pop_fire);
            if (hit_fire && sum[AW]) sat_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && miss_fire) begin
            node_q[wr_ptr]  <= push_node_idx;
            accum_q[wr_ptr] <= push_accum_val;
        end else if (!clr && hit_fire) begin
            accum_q[hit_idx] <= sat_sum;
        end
    end

endmodule

// File: tb/tb_node_work_queue.sv
// Directed bench for node_work_queue: vector table plus corner sequences.
module tb_node_work_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [8:0]  push_node_idx = '0;
    logic [23:0] push_accum_val = '0;
    logic        pop_valid;
    logic        pop_ready = 1'b0;
    logic [8:0]  pop_node_idx;
    logic [23:0] pop_accum_val;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic        sat_flag;

    int errs = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    node_work_queue dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_node_idx(push_node_idx), .push_accum_val(push_accum_val),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_node_idx(pop_node_idx), .pop_accum_val(pop_accum_val),
        .count(count), .full(full), .empty(empty), .sat_flag(sat_flag)
    );

    typedef struct {
        bit pv; int node; int val; bit pr; bit cl;
        int ecnt; bit evld; int enode; int eval; bit esat;
    } vec_t;

    vec_t vt [21];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic drive(input bit pv, input int node, input int val,
                         input bit pr, input bit cl);
        push_valid     = pv;
        push_node_idx  = 9'(node);
        push_accum_val = 24'(val);
        pop_ready      = pr;
        clr            = cl;
    endtask

    task automatic step(input bit pv, input int node, input int val,
                        input bit pr, input bit cl);
        drive(pv, node, val, pr, cl);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
    endtask

    int qn[$];
    int qv[$];

    initial begin
        vt[0]  = '{1, 5, 3, 0, 0,  1, 1, 5, 3, 0};
        vt[1]  = '{1, 7, 1, 0, 0,  2, 1, 5, 3, 0};
        vt[2]  = '{1, 9, 2, 0, 0,  3, 1, 5, 3, 0};
        vt[3]  = '{0, 0, 0, 1, 0,  2, 1, 7, 1, 0};
        vt[4]  = '{0, 0, 0, 1, 0,  1, 1, 9, 2, 0};
        vt[5]  = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0};
        vt[6]  = '{1, 4, 10, 0, 0, 1, 1, 4, 10, 0};
        vt[7]  = '{1, 4, 6, 0, 0,  1, 1, 4, 16, 0};
        vt[8]  = '{1, 4, 0, 0, 0,  1, 1, 4, 16, 0};
        vt[9]  = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0};
        vt[10] = '{1, 8, 5, 0, 0,  1, 1, 8, 5, 0};
        vt[11] = '{1, 8, 2, 1, 0,  1, 1, 8, 2, 0};
        vt[12] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0};
        vt[13] = '{1, 3, 'hFFFFF0, 0, 0, 1, 1, 3, 'hFFFFF0, 0};
        vt[14] = '{1, 3, 'h20, 0, 0, 1, 1, 3, 'hFFFFFF, 1};
        vt[15] = '{1, 6, 1, 0, 0,  2, 1, 3, 'hFFFFFF, 1};
        vt[16] = '{1, 2, 1, 1, 1,  0, 0, 0, 0, 0};
        vt[17] = '{1, 2, 7, 0, 0,  1, 1, 2, 7, 0};
        vt[18] = '{1, 2, 1, 1, 0,  1, 1, 2, 1, 0};
        vt[19] = '{0, 2, 9, 0, 0,  1, 1, 2, 1, 0};
        vt[20] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0};

        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_push_ready", int'(push_ready), 1);
        chk("rst_sat", int'(sat_flag), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // head race: popped value must be the pre-add 5
        for (int i = 0; i < 21; i++) begin
            if (i == 11) begin
                drive(1, 8, 2, 1, 0);
                #1;
                chk("race_pop_val", int'(pop_accum_val), 5);
                chk("race_ready", int'(push_ready), 1);
                @(posedge clk);
                #1;
                drive(0, 0, 0, 0, 0);
            end else begin
                step(vt[i].pv, vt[i].node, vt[i].val, vt[i].pr, vt[i].cl);
            end
            chk($sformatf("v%0d_count", i), int'(count), vt[i].ecnt);
            chk($sformatf("v%0d_empty", i), int'(empty), int'(vt[i].ecnt == 0));
            chk($sformatf("v%0d_pop_valid", i), int'(pop_valid), int'(vt[i].evld));
            chk($sformatf("v%0d_sat", i), int'(sat_flag), int'(vt[i].esat));
            if (vt[i].evld) begin
                chk($sformatf("v%0d_head_node", i), int'(pop_node_idx), vt[i].enode);
                chk($sformatf("v%0d_head_val", i), int'(pop_accum_val), vt[i].eval);
            end
        end

        // full queue behaviour
        for (int n = 0; n < 32; n++) step(1, n, n, 0, 0);
        chk("full_count", int'(count), 32);
        chk("full_flag", int'(full), 1);
        push_valid = 1'b0;
        push_node_idx = 9'd40;
        #1;
        chk("full_ready_40", int'(push_ready), 0);
        push_node_idx = 9'd12;
        #1;
        chk("full_ready_12", int'(push_ready), 1);
        @(posedge clk);
        #1;
        step(1, 12, 5, 0, 0);
        chk("full_hit_count", int'(count), 32);
        step(0, 0, 0, 1, 0);
        chk("full_pop_count", int'(count), 31);
        step(1, 40, 40, 0, 0);
        chk("full_40_count", int'(count), 32);
        for (int n = 1; n < 33; n++) begin
            chk("drain_node", int'(pop_node_idx), (n == 32) ? 40 : n);
            chk("drain_val", int'(pop_accum_val),
                (n == 32) ? 40 : ((n == 12) ? 17 : n));
            step(0, 0, 0, 1, 0);
        end
        chk("drain_empty", int'(empty), 1);

        // wrap-around with concurrent push/pop against a queue model
        qn.delete();
        qv.delete();
        for (int k = 0; k < 3; k++) begin
            step(1, 300 + k, k + 1, 0, 0);
            qn.push_back(300 + k);
            qv.push_back(k + 1);
        end
        for (int k = 0; k < 100; k++) begin
            drive(1, 50 + k, 1000 + k, 1, 0);
            #1;
            chk("wrap_head_node", int'(pop_node_idx), qn[0]);
            chk("wrap_head_val", int'(pop_accum_val), qv[0]);
            @(posedge clk);
            #1;
            drive(0, 0, 0, 0, 0);
            void'(qn.pop_front());
            void'(qv.pop_front());
            qn.push_back(50 + k);
            qv.push_back(1000 + k);
            chk("wrap_count", int'(count), 3);
        end
        step(1, 149, 1, 0, 0);
        chk("wrap_coalesce_count", int'(count), 3);
        step(0, 0, 0, 0, 1);
        chk("clr_count", int'(count), 0);
        chk("clr_sat", int'(sat_flag), 0);

        // asynchronous reset in the middle of a run
        for (int k = 0; k < 6; k++) step(1, 20 + k, 1, 0, 0);
        chk("mid_count", int'(count), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_pop_valid", int'(pop_valid), 0);
        chk("mid_rst_count", int'(count), 0);
        #1;
        rst_n = 1'b1;
        step(1, 1, 1, 0, 0);
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_node", int'(pop_node_idx), 1);
        chk("post_rst_val", int'(pop_accum_val), 1);
        step(0, 0, 0, 1, 0);
        chk("post_rst_empty", int'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
